// File: rtl/barrel_rotate_pipe.sv
// barrel_rotate_pipe: valid/ready pipelined barrel shifter/rotator, one stage per amount bit
module barrel_rotate_pipe #(
  parameter int WIDTH = 8,
  parameter int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_mode
);
  logic             valid_q [AW];
  logic [WIDTH-1:0] data_q  [AW];
  logic [AW-1:0]    amt_q   [AW];
  logic [2:0]       mode_q  [AW];
  logic             valid_s [AW];
  logic [WIDTH-1:0] data_s  [AW];
  logic [AW-1:0]    amt_s   [AW];
  logic [2:0]       mode_s  [AW];
  logic             advance;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [2:0] m, input int n);
    step = m == 3'd0 ? (d << n) | (d >> (WIDTH - n)) :
           m == 3'd1 ? (d >> n) | (d << (WIDTH - n)) :
           m == 3'd2 ? d << n :
           m == 3'd3 ? d >> n :
           m == 3'd4 ? (d >> n) | ({WIDTH{d[WIDTH-1]}} << (WIDTH - n)) : d;
  endfunction

  assign advance   = ~valid_q[AW-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[AW-1];
  assign out_data  = data_q[AW-1];
  assign out_mode  = mode_q[AW-1];

  always_comb begin
    valid_s[0] = in_valid;
    data_s[0]  = in_data;
    amt_s[0]   = in_amt;
    mode_s[0]  = in_mode;
    for (int k = 1; k < AW; k++) begin
      valid_s[k] = valid_q[k-1];
      data_s[k]  = data_q[k-1];
      amt_s[k]   = amt_q[k-1];
      mode_s[k]  = mode_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < AW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < AW; k++) begin
        valid_q[k] <= valid_s[k];
        data_q[k]  <= amt_s[k][k] ? step(data_s[k], mode_s[k], 1 << k) : data_s[k];
        amt_q[k]   <= amt_s[k];
        mode_q[k]  <= mode_s[k];
      end
    end
endmodule

// File: tb/tb_barrel_rotate_pipe.sv
// tb_barrel_rotate_pipe: randomized and directed checks against a behavioural shift model
module tb_barrel_rotate_pipe;
  logic       clk = 0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [2:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_mode;

  barrel_rotate_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic [2:0] m; int c;} item_t;
  item_t      sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_pop = 0;
  logic       bp = 0;
  logic       stall_prev = 0;
  logic [7:0] prev_data;
  logic [2:0] prev_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input int a, input logic [2:0] m);
    logic signed [7:0] s;
    logic signed [7:0] r;
    s = d;
    r = s >>> a;
    case (m)
      3'd0: return (d << a) | (d >> (8 - a));
      3'd1: return (d >> a) | (d << (8 - a));
      3'd2: return d << a;
      3'd3: return d >> a;
      3'd4: return r;
      default: return d;
    endcase
  endfunction

  task automatic tick(input logic v, input logic [7:0] d, input logic [2:0] a, input logic [2:0] m,
                      input logic [7:0] exp, output logic acc);
    item_t it;
    @(negedge clk);
    in_valid = v; in_data = d; in_amt = a; in_mode = m;
    out_ready = bp ? 1'($urandom % 2) : 1'b1;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (stall_prev) begin
      check("hold_data", out_data, prev_data);
      check("hold_mode", out_mode, prev_mode);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("extra_result", out_valid, 0);
      else begin
        it = sb.pop_front();
        n_pop++;
        check("data", out_data, it.d);
        check("mode", out_mode, it.m);
        if (!bp) check("latency", cyc - it.c, 3);
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_data = out_data;
    prev_mode = out_mode;
    acc = v && in_ready;
    if (acc) sb.push_back('{exp, m, cyc});
    cyc++;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m, input logic [7:0] exp);
    logic acc;
    int g = 0;
    do begin
      tick(1'b1, d, a, m, exp, acc);
      g++;
    end while (!acc && g < 100);
    check("accept", acc, 1);
  endtask

  task automatic send_rand();
    logic [7:0] d;
    logic [2:0] a, m;
    d = 8'($urandom);
    a = 3'($urandom);
    m = 3'($urandom_range(0, 7));
    send(d, a, m, model(d, a, m));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 3'($urandom), 3'($urandom), 8'h00, acc);
  endtask

  task automatic drain();
    logic acc;
    int g = 0;
    while ((sb.size() != 0 || out_valid) && g < 200) begin
      tick(1'b0, 8'h00, 3'd0, 3'd0, 8'h00, acc);
      g++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int p0;
    rst_n = 0; in_valid = 0; in_data = 0; in_amt = 0; in_mode = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mode", out_mode, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1;
    repeat (3) send_rand();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    sb.delete();
    stall_prev = 0;
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    idle(8);
    send(8'h62, 3, 0, 8'h13);
    send(8'h62, 3, 1, 8'h4C);
    send(8'h62, 3, 2, 8'h10);
    send(8'h62, 3, 3, 8'h0C);
    for (int m = 0; m < 8; m++) send(8'h62, 0, 3'(m), 8'h62);
    send(8'h90, 2, 4, 8'hE4);
    send(8'h70, 2, 4, 8'h1C);
    send(8'h62, 5, 6, 8'h62);
    send(8'h62, 7, 7, 8'h62);
    drain();
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 8; a++) send(8'h62, 3'(a), 3'(m), model(8'h62, a, 3'(m)));
    drain();
    for (int i = 0; i < 8; i++) begin
      send_rand();
      idle(1);
    end
    drain();
    bp = 1;
    p0 = n_pop;
    repeat (10) send_rand();
    drain();
    check("bp_count", n_pop - p0, 10);
    repeat (40) begin
      send_rand();
      if ($urandom % 4 == 0) idle(1);
    end
    drain();
    bp = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
